serial_subtractor: RTL and testbench

Sequential bit-serial 6-bit subtractor with borrow in/out and signed overflow detection. It is the inverse companion to the combinational carry-ripple adder. It computes x − y − b_in one bit per clock under a start/done handshake. It is used where a narrow datapath needs a subtractor and the result may take several cycles.

---
 rtl/serial_subtractor_if.sv | 29 ++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor_if : start/done handshake and result bus           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface serial_subtractor_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             overflow;

  modport master (
    output start, x, y, b_in,
    input  busy, done, diff, b_out, overflow
  );

  modport slave (
    input  start, x, y, b_in,
    output busy, done, diff, b_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor : bit-serial x - y - b_in, LSB first, one bit/clk  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  serial_subtractor_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic [CW-1:0]    count;
  logic             borrow;
  logic             x_sign;
  logic             y_sign;
  logic [WIDTH-1:0] diff_r;
  logic             b_out_r;
  logic             overflow_r;

  logic             a;
  logic             b;
  logic             d;
  logic             br_next;
  logic             load;
  logic             step;
  logic             commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (count == LAST) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One full-subtractor cell; the difference bit enters the work register at the MSB.
  always_comb begin
    a         = x_sr[0];
    b         = y_sr[0];
    d         = a ^ b ^ borrow;
    br_next   = (~a & b) | (~(a ^ b) & borrow);
    work_next = {d, work[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_sr       <= '0;
      y_sr       <= '0;
      work       <= '0;
      count      <= '0;
      borrow     <= 1'b0;
      x_sign     <= 1'b0;
      y_sign     <= 1'b0;
      diff_r     <= '0;
      b_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (load) begin
      x_sr   <= bus.x;
      y_sr   <= bus.y;
      work   <= '0;
      count  <= '0;
      borrow <= bus.b_in;
      x_sign <= bus.x[WIDTH-1];
      y_sign <= bus.y[WIDTH-1];
    end else if (step) begin
      x_sr   <= x_sr >> 1;
      y_sr   <= y_sr >> 1;
      work   <= work_next;
      borrow <= br_next;
      count  <= count + 1'b1;
      // Sign bits come from the start-time copies; the shift registers are empty by now.
      if (commit) begin
        diff_r     <= work_next;
        b_out_r    <= br_next;
        overflow_r <= (x_sign != y_sign) && (work_next[WIDTH-1] != x_sign);
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.diff     = diff_r;
  assign bus.b_out    = b_out_r;
  assign bus.overflow = overflow_r;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_subtractor : randomized and directed bench with ref model  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(6)) ifc();

  serial_subtractor #(.WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, overflow from the sign rule on the true result.
  function automatic void model(input logic [5:0] xv, input logic [5:0] yv, input logic bv,
                                output logic [5:0] dv, output logic bo, output logic ov);
    int r;
    r  = int'(xv) - int'(yv) - int'(bv);
    dv = 6'(r);
    bo = (r < 0);
    ov = (xv[5] != yv[5]) && (dv[5] != xv[5]);
  endfunction

  // Presents operands with start high across one edge; returns just after the accepting edge.
  task automatic launch(input logic [5:0] xv, input logic [5:0] yv, input logic bv);
    ifc.x     = xv;
    ifc.y     = yv;
    ifc.b_in  = bv;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    ifc.x     = 6'($urandom);
    ifc.y     = 6'($urandom);
    ifc.b_in  = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!ifc.done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({ifc.busy, ifc.done, ifc.diff, ifc.b_out, ifc.overflow} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b diff=%b b_out=%b ovf=%b want all 0",
               ifc.busy, ifc.done, ifc.diff, ifc.b_out, ifc.overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [5:0] tx[6] = '{6'b000000, 6'b000010, 6'b000010, 6'b000001, 6'b010000, 6'b100000};
    logic [5:0] ty[6] = '{6'b000000, 6'b000001, 6'b000001, 6'b000010, 6'b110000, 6'b000001};
    logic       tb[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0] ed[6] = '{6'b000000, 6'b000000, 6'b000001, 6'b111111, 6'b100000, 6'b011111};
    logic       eb[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       eo[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      launch(tx[i], ty[i], tb[i]);
      checks++;
      if (ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_busy_after_accept got busy=%b done=%b want busy=1 done=0",
                 i, ifc.busy, ifc.done);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 6) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d want 6", i, cyc);
      end
      checks++;
      if (ifc.diff !== ed[i] || ifc.b_out !== eb[i] || ifc.overflow !== eo[i] || ifc.busy !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_result got diff=%b b_out=%b ovf=%b busy=%b want diff=%b b_out=%b ovf=%b busy=1",
                 i, ifc.diff, ifc.b_out, ifc.overflow, ifc.busy, ed[i], eb[i], eo[i]);
      end
      tick();
      checks++;
      if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.diff !== ed[i]) begin
        errors++;
        $display("FAIL dir%0d_return_idle got busy=%b done=%b diff=%b want busy=0 done=0 diff=%b",
                 i, ifc.busy, ifc.done, ifc.diff, ed[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] xv, yv, dv, prev_d;
    logic       bv, bo, ov;
    int         cyc;
    prev_d = ifc.diff;
    for (int i = 0; i < 40; i++) begin
      xv = 6'($urandom);
      yv = 6'($urandom);
      bv = 1'($urandom);
      model(xv, yv, bv, dv, bo, ov);
      launch(xv, yv, bv);
      tick();
      tick();
      checks++;
      if (ifc.diff !== prev_d) begin
        errors++;
        $display("FAIL rnd%0d_hold_while_busy got diff=%b want %b", i, ifc.diff, prev_d);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 4 || ifc.diff !== dv || ifc.b_out !== bo || ifc.overflow !== ov) begin
        errors++;
        $display("FAIL rnd%0d x=%b y=%b b=%b got cyc=%0d diff=%b b_out=%b ovf=%b want cyc=4 diff=%b b_out=%b ovf=%b",
                 i, xv, yv, bv, cyc, ifc.diff, ifc.b_out, ifc.overflow, dv, bo, ov);
      end
      prev_d = dv;
      tick();
    end
  endtask

  task automatic test_start_ignored();
    logic [5:0] dv;
    logic       bo, ov;
    int         ndone = 0;
    logic [5:0] got_d = '0;
    logic       got_b = 1'b0, got_o = 1'b0;
    model(6'b101101, 6'b010011, 1'b1, dv, bo, ov);
    launch(6'b101101, 6'b010011, 1'b1);
    tick();
    ifc.x     = 6'b000001;
    ifc.y     = 6'b111110;
    ifc.b_in  = 1'b0;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ifc.done) begin
        ndone++;
        got_d = ifc.diff;
        got_b = ifc.b_out;
        got_o = ifc.overflow;
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignore_start_done_count got %0d want 1", ndone);
    end
    checks++;
    if (got_d !== dv || got_b !== bo || got_o !== ov || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result got diff=%b b_out=%b ovf=%b busy=%b want diff=%b b_out=%b ovf=%b busy=0",
               got_d, got_b, got_o, ifc.busy, dv, bo, ov);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] dv;
    logic       bo, ov;
    int         ndone = 0;
    int         cyc;
    launch(6'b000001, 6'b000010, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({ifc.busy, ifc.done, ifc.diff, ifc.b_out, ifc.overflow} !== 10'd0) begin
      errors++;
      $display("FAIL midreset_outputs got busy=%b done=%b diff=%b b_out=%b ovf=%b want all 0",
               ifc.busy, ifc.done, ifc.diff, ifc.b_out, ifc.overflow);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ifc.done || ifc.busy) ndone++;
    end
    checks++;
    if (ndone !== 0 || ifc.diff !== 6'd0) begin
      errors++;
      $display("FAIL midreset_no_done got active_cycles=%0d diff=%b want 0 and 000000", ndone, ifc.diff);
    end
    model(6'b011010, 6'b000111, 1'b1, dv, bo, ov);
    launch(6'b011010, 6'b000111, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== 6 || ifc.diff !== dv || ifc.b_out !== bo || ifc.overflow !== ov) begin
      errors++;
      $display("FAIL midreset_fresh_op got cyc=%0d diff=%b b_out=%b ovf=%b want cyc=6 diff=%b b_out=%b ovf=%b",
               cyc, ifc.diff, ifc.b_out, ifc.overflow, dv, bo, ov);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] dv;
    logic       bo, ov;
    int         prev = -1, first = -1, nd = 0, bad_gap = 0, bad_res = 0, idle_between = 0;
    int         idle_at[$];
    model(6'b110011, 6'b011101, 1'b0, dv, bo, ov);
    ifc.x     = 6'b110011;
    ifc.y     = 6'b011101;
    ifc.b_in  = 1'b0;
    ifc.start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (!ifc.busy) idle_at.push_back(i);
      if (ifc.done) begin
        if (prev >= 0 && (i - prev) != 8) bad_gap++;
        if (ifc.diff !== dv || ifc.b_out !== bo || ifc.overflow !== ov) bad_res++;
        if (first < 0) first = i;
        prev = i;
        nd++;
      end
    end
    ifc.start = 1'b0;
    foreach (idle_at[k]) if (idle_at[k] > first && idle_at[k] < prev) idle_between++;
    checks++;
    if (nd !== 3 || bad_gap !== 0) begin
      errors++;
      $display("FAIL b2b_done_spacing got dones=%0d bad_gaps=%0d want 3 and 0", nd, bad_gap);
    end
    checks++;
    if (bad_res !== 0) begin
      errors++;
      $display("FAIL b2b_results got bad=%0d want 0", bad_res);
    end
    checks++;
    if (idle_between !== nd - 1) begin
      errors++;
      $display("FAIL b2b_idle_gap got idle_cycles=%0d want %0d", idle_between, nd - 1);
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.x     = '0;
    ifc.y     = '0;
    ifc.b_in  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
